// File: rtl/display_pkg.sv
// Shared display definitions: scan FSM states, the blank segment pattern and
// the active-low hex glyph table, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Standard hex glyphs, index = nibble value, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/display_scan_driver_if.sv
// Bundle between the datapath/refresh logic (master) and the scan driver
// (slave). N_DIGITS must match the driver it is connected to.
interface display_scan_driver_if #(
  parameter int N_DIGITS = 4
);

  logic                  scan_tick;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  frame_done;

  modport master (
    output scan_tick, value, digit_en,
    input  an, seg, frame_done
  );

  modport slave (
    input  scan_tick, value, digit_en,
    output an, seg, frame_done
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph, shared by display blocks.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver.
// Each refresh strobe seen while a digit is shown moves to the next digit
// through a dead-time window with all anodes off. A full frame is taken from
// one shadow copy of the value, captured whenever scanning enters digit 0.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).
module display_scan_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 8
)(
  input logic                  clk,
  input logic                  rst,
  display_scan_driver_if.slave bus
);

  localparam int               IDX_W      = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]       BLANK_LAST = 8'(BLANK_CYCLES - 1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            blank_cnt_q, blank_cnt_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic                  primed_q, primed_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wrap;
  logic [4*N_DIGITS-1:0] src_word;
  logic [3:0]            src_nibble;
  logic [6:0]            glyph;
  logic [N_DIGITS-1:0]   lz_dark;

  // Before the first frame, and on the wrap cycle, the digit being prepared
  // comes from the live value (it is what the shadow is about to hold).
  assign src_word   = (wrap || !primed_q) ? bus.value : shadow_q;
  assign src_nibble = src_word[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_decode (
    .nibble (src_nibble),
    .seg    (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 goes dark when it and every nibble above it are zero.
  always_comb begin
    logic zero_above;
    lz_dark    = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (src_word[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Scan FSM next state: dead-time countdown in BLANK, wait for a strobe in SHOW.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    blank_cnt_d = blank_cnt_q;
    primed_d    = primed_q;
    wrap        = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d  = SHOW;
          primed_d = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q + 8'd1;
        end
      end
      SHOW: begin
        if (bus.scan_tick) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Output next values: glyph of the upcoming digit, anode only while showing.
  always_comb begin
    shadow_d     = shadow_q;
    seg_d        = lz_dark[idx_d] ? SEG_BLANK : glyph;
    an_d         = '1;
    frame_done_d = wrap;
    if (wrap || (!primed_q && state_d == SHOW)) begin
      shadow_d = bus.value;
    end
    if (state_d == SHOW && bus.digit_en[idx_d] && !lz_dark[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
  end

  // State and registered outputs, synchronous reset to all-dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      blank_cnt_q  <= '0;
      shadow_q     <= '0;
      primed_q     <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      blank_cnt_q  <= blank_cnt_d;
      shadow_q     <= shadow_d;
      primed_q     <= primed_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver (N_DIGITS=4, BLANK_CYCLES=2).
// Expected leading-zero behaviour follows LEADING_ZERO_BLANK_EN.
module tb_display_scan_driver;
  import display_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  typedef struct {
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        chk_seg;
    logic        exp_fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];

  display_scan_driver_if #(.N_DIGITS(4)) bus ();

  display_scan_driver #(
    .N_DIGITS     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] en, input logic tick);
    bus.value     = v;
    bus.digit_en  = en;
    bus.scan_tick = tick;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One strobe from SHOW, then dead time, then the next digit's dwell.
  task automatic stepDigit(input vec_t v, input int row);
    applyStimulus(v.value, v.digit_en, 1'b1);
    @(negedge clk);
    bus.scan_tick = 1'b0;
    checkOutput($sformatf("row%0d frame_done", row), 32'(bus.frame_done), 32'(v.exp_fd));
    checkOutput($sformatf("row%0d dead1 an", row), 32'(bus.an), 32'hF);
    @(negedge clk);
    checkOutput($sformatf("row%0d dead2 an", row), 32'(bus.an), 32'hF);
    @(negedge clk);
    checkOutput($sformatf("row%0d show an", row), 32'(bus.an), 32'(v.exp_an));
    if (v.chk_seg) checkOutput($sformatf("row%0d show seg", row), 32'(bus.seg), 32'(v.exp_seg));
    @(negedge clk);
    checkOutput($sformatf("row%0d dwell an", row), 32'(bus.an), 32'(v.exp_an));
  endtask

  initial begin
    vec_t hv;
    vecs[0]  = '{16'h1234, 4'hF,    4'b1101, 7'h30, 1'b1, 1'b0};
    vecs[1]  = '{16'h1234, 4'hF,    4'b1011, 7'h24, 1'b1, 1'b0};
    vecs[2]  = '{16'hABCD, 4'hF,    4'b0111, 7'h79, 1'b1, 1'b0};
    vecs[3]  = '{16'hABCD, 4'hF,    4'b1110, 7'h21, 1'b1, 1'b1};
    vecs[4]  = '{16'hABCD, 4'b1011, 4'b1101, 7'h46, 1'b1, 1'b0};
    vecs[5]  = '{16'hABCD, 4'b1011, 4'b1111, 7'h03, 1'b0, 1'b0};
    vecs[6]  = '{16'hABCD, 4'b1011, 4'b0111, 7'h08, 1'b1, 1'b0};
    vecs[7]  = '{16'hABCD, 4'hF,    4'b1110, 7'h21, 1'b1, 1'b1};
    vecs[8]  = '{16'h0050, 4'hF,    4'b1101, 7'h46, 1'b1, 1'b0};
    vecs[9]  = '{16'h0050, 4'hF,    4'b1011, 7'h03, 1'b1, 1'b0};
    vecs[10] = '{16'h0050, 4'hF,    4'b0111, 7'h08, 1'b1, 1'b0};
    vecs[11] = '{16'h0050, 4'hF,    4'b1110, 7'h40, 1'b1, 1'b1};
    vecs[12] = '{16'h0050, 4'hF,    4'b1101, 7'h12, 1'b1, 1'b0};
    vecs[13] = '{16'h0050, 4'hF,    LZ ? 4'b1111 : 4'b1011, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0};
    vecs[14] = '{16'h0050, 4'hF,    LZ ? 4'b1111 : 4'b0111, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0};

    // Reset state.
    rst = 1'b1;
    applyStimulus(16'h1234, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset an", 32'(bus.an), 32'hF);
    checkOutput("reset seg", 32'(bus.seg), 32'(SEG_BLANK));
    checkOutput("reset frame_done", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;

    // First frame: glyph loads during dead time, then digit 0 lights.
    @(negedge clk);
    checkOutput("first blank an", 32'(bus.an), 32'hF);
    checkOutput("first blank seg preload", 32'(bus.seg), 32'h19);
    @(negedge clk);
    checkOutput("first digit0 an", 32'(bus.an), 32'hE);
    checkOutput("first digit0 seg", 32'(bus.seg), 32'h19);
    repeat (3) @(negedge clk);
    checkOutput("digit0 dwell an", 32'(bus.an), 32'hE);

    for (int i = 0; i < 15; i++) stepDigit(vecs[i], i);

    // Strobe in the first BLANK cycle is ignored and not queued.
    applyStimulus(16'h0050, 4'hF, 1'b1);
    @(negedge clk);
    checkOutput("blank tick frame_done", 32'(bus.frame_done), 32'h1);
    @(negedge clk);
    bus.scan_tick = 1'b0;
    checkOutput("blank tick fd pulse", 32'(bus.frame_done), 32'h0);
    checkOutput("blank tick an", 32'(bus.an), 32'hF);
    @(negedge clk);
    checkOutput("blank tick digit0 an", 32'(bus.an), 32'hE);
    checkOutput("blank tick digit0 seg", 32'(bus.seg), 32'h40);
    repeat (4) @(negedge clk);
    checkOutput("blank tick no advance", 32'(bus.an), 32'hE);
    hv = '{16'h0050, 4'hF, 4'b1101, 7'h12, 1'b1, 1'b0};
    stepDigit(hv, 20);

    // Strobe held high: one advance per SHOW entry, every 3 clocks.
    applyStimulus(16'h1234, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("held digit2 an", 32'(bus.an), LZ ? 32'hF : 32'hB);
    repeat (3) @(negedge clk);
    checkOutput("held digit3 an", 32'(bus.an), LZ ? 32'hF : 32'h7);
    @(negedge clk);
    checkOutput("held wrap frame_done", 32'(bus.frame_done), 32'h1);
    repeat (2) @(negedge clk);
    bus.scan_tick = 1'b0;
    checkOutput("held digit0 an", 32'(bus.an), 32'hE);
    checkOutput("held digit0 seg", 32'(bus.seg), 32'h19);

    // Reset while digit 2 is lit.
    hv = '{16'h1234, 4'hF, 4'b1101, 7'h30, 1'b1, 1'b0};
    stepDigit(hv, 21);
    hv = '{16'h1234, 4'hF, 4'b1011, 7'h24, 1'b1, 1'b0};
    stepDigit(hv, 22);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midscan reset an", 32'(bus.an), 32'hF);
    checkOutput("midscan reset seg", 32'(bus.seg), 32'(SEG_BLANK));
    checkOutput("midscan reset frame_done", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset blank an", 32'(bus.an), 32'hF);
    @(negedge clk);
    checkOutput("post reset digit0 an", 32'(bus.an), 32'hE);
    checkOutput("post reset digit0 seg", 32'(bus.seg), 32'h19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
